pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
Consumer end of the tone-generator sample stream. Accepts unsigned WIDTH-bit samples from a waveform generator (triangle, square, etc.) over a valid/ready handshake and buffers them in a small FIFO. It pops one sample per PWM period and converts it to a single-bit pulse-width-modulated output that drives the board's audio pin through an RC filter. It reports underruns when the generator does not keep pace with the sample rate (clk / 2^WIDTH).

Parameters:
WIDTH, 8, sample width; PWM period is 2^WIDTH clk cycles
DEPTH, 4, FIFO depth in samples; power of 2, minimum 2
UCNT_W, 16, width of the saturating underrun counter

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
in_data  input  WIDTH  unsigned sample from generator
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  FIFO can accept a sample this cycle
pwm_out  output  1  PWM audio bit, registered
period_start  output  1  high during the first cycle of each PWM period (ctr==0)
underrun  output  1  one-cycle pulse when a period starts with no fresh sample
underrun_count  output  UCNT_W  saturating count of underruns
fill  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst high at posedge):
  - ctr=0, duty=0, pwm_out=0, FIFO empty (fill=0), underrun=0, underrun_count=0.
  - Reset has priority over all other activity and takes effect mid-period; any samples in the FIFO are discarded.
- Handshake:
  - Push occurs on a posedge with in_valid && in_ready.
  - in_ready = (fill != DEPTH), decoded from registered state only, with no combinational path from in_valid.
  - When full, in_ready is low even if a pop happens in the same cycle; no push-through on full.
  - in_data is don't-care when in_valid is low.
- Period counter:
  - ctr is WIDTH bits and increments every cycle, wrapping 2^WIDTH-1 -> 0.
  - period_start = (ctr==0).
- Sample load, on the posedge where ctr==2^WIDTH-1 (the last cycle of a period):
  - FIFO non-empty: pop the head into duty.
  - FIFO empty: keep the previous duty (repeat last sample), pulse underrun for the following cycle, and increment underrun_count, saturating at 2^UCNT_W-1.
- FIFO visibility: the FIFO is registered. A sample pushed on the load posedge itself is not visible to that load; it causes an underrun and is used one period later. Simultaneous push and pop when non-full updates fill by +0.
- PWM output:
  - pwm_out is registered as pwm_out <= (ctr_next < duty_next), so it is aligned with ctr: high in exactly duty cycles of each period, starting at the ctr==0 cycle.
  - duty=0 gives constant low. duty=2^WIDTH-1 gives high for all but the last cycle of the period.
- Latency: a sample pushed into an empty FIFO at least one cycle before the load posedge appears on pwm_out at the next period_start.
- Ordering: FIFO order is strict; samples are never dropped or duplicated except the repeat on underrun.

Decomposition:
- Shared package audio_pkg:
  - clog2 function
  - default SAMPLE_WIDTH=8
  - PWM period constant derived from WIDTH, shared with the tone generators for sample-rate math.
- One sub-module, sample_fifo (WIDTH, DEPTH):
  - Synchronous FIFO with push/pop, full/empty, fill count, and registered head.
  - Uses wrap-around pointers with an extra MSB to distinguish full from empty.
- pwm_audio_out holds the counter, duty register, load logic and underrun counter.

Test Plan:
- Reset, then idle 600 cycles with in_valid=0 -> pwm_out stays 0, period_start pulses every 256 cycles, underrun pulses twice, underrun_count=2, in_ready=1, fill=0.
- Push 64 at ctr=10 -> fill=1 until the load, then pwm_out high for exactly 64 consecutive cycles starting at the next period_start; no underrun that period.
- Push 0, 255, 128, 1 back-to-back -> successive periods give high counts 0, 255, 128, 1; then the next period repeats 1 with an underrun pulse.
- Hold in_valid=1 with no pops until full -> in_ready falls after 4 accepts (fill=4), and the 5th sample is held until the load frees a slot. At load, in_ready stays low that cycle and rises the following cycle.
- Push a sample exactly on the load posedge with the FIFO empty -> underrun pulse, old duty repeated, the sample appears one period later.
- UCNT_W=4 with no input for 20 periods -> underrun_count saturates at 15. Assert rst mid-period (ctr=100, fill=3) -> next cycle pwm_out=0, fill=0, ctr=0, count=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and helpers, used by the PWM sink and the tone generators
// for sample-rate math.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One PWM period (and thus one sample) lasts 2^width clocks.
  function automatic int pwm_period(input int width);
    return 1 << width;
  endfunction

  localparam int PWM_PERIOD = pwm_period(SAMPLE_WIDTH);

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO; head is read straight from the storage registers
// so a sample becomes visible the cycle after it is pushed.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   fill
);

  localparam int AW = clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio sink: buffers generator samples, loads one per 2^WIDTH-cycle period
// into the duty register and flags periods that start without a fresh sample.
module pwm_audio_out
  import audio_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_WIDTH,
  parameter int DEPTH  = 4,
  parameter int UCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  underrun,
  output logic [UCNT_W-1:0]     underrun_count,
  output logic [clog2(DEPTH):0] fill
);

  localparam logic [WIDTH-1:0] CTR_LAST = WIDTH'(pwm_period(WIDTH) - 1);

  logic [WIDTH-1:0] ctr, ctr_next, duty, duty_next, head;
  logic             full, empty, load, pop, starve;

  assign in_ready     = !full;
  assign period_start = (ctr == '0);
  assign load         = (ctr == CTR_LAST);
  assign pop          = load && !empty;
  assign starve       = load && empty;
  assign ctr_next     = ctr + WIDTH'(1);
  assign duty_next    = pop ? head : duty;

  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  // Compare against next-state values so pwm_out lines up with ctr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr            <= '0;
      duty           <= '0;
      pwm_out        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      ctr      <= ctr_next;
      duty     <= duty_next;
      pwm_out  <= (ctr_next < duty_next);
      underrun <= starve;
      if (starve && (underrun_count != '1))
        underrun_count <= underrun_count + UCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: idle, latency, ordering, full/backpressure,
// load-edge push, counter saturation and mid-period reset.
module tb_pwm_audio_out;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int UCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, pwm_out, period_start, underrun;
  logic [UCNT_W-1:0] underrun_count;
  logic [2:0]        fill;

  int tests = 0, fails = 0;
  int tctr = 0, ps_err = 0, ur_cnt = 0, ur_mis = 0;
  int h, s, hi;
  logic u;

  pwm_audio_out #(.WIDTH(WIDTH), .DEPTH(DEPTH), .UCNT_W(UCNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .fill           (fill)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; tctr mirrors the DUT period counter.
  task automatic step();
    @(posedge clk); #1;
    tctr = (tctr + 1) % 256;
    if (period_start !== (tctr == 0)) ps_err++;
    if (underrun === 1'b1) begin
      ur_cnt++;
      if (tctr != 0) ur_mis++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tctr = 0;
  endtask

  task automatic run_to(input int t);
    while (tctr != t) step();
  endtask

  // Called at ctr==0; samples a whole period and ends at the next ctr==0.
  task automatic measure(input int duty, output int highs, output int shape, output logic ur0);
    highs = 0; shape = 0; ur0 = underrun;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) highs++;
      if (pwm_out !== (i < duty)) shape++;
      step();
    end
  endtask

  initial begin
    int seq[4];
    int drain[4];
    seq   = '{0, 255, 128, 1};
    drain = '{20, 30, 40, 50};

    // Reset state and idle behaviour
    do_reset();
    check("rst_pwm", pwm_out, 0);
    check("rst_fill", fill, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ucnt", underrun_count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_pstart", period_start, 1);
    hi = 0;
    repeat (600) begin
      step();
      if (pwm_out !== 1'b0) hi++;
    end
    check("idle_pwm_high", hi, 0);
    check("idle_pstart_err", ps_err, 0);
    check("idle_ur_pulses", ur_cnt, 2);
    check("idle_ur_align", ur_mis, 0);
    check("idle_ucnt", underrun_count, 2);
    check("idle_ready", in_ready, 1);
    check("idle_fill", fill, 0);

    // Single sample latency
    run_to(10);
    in_valid = 1'b1; in_data = 8'd64;
    step();
    in_valid = 1'b0;
    check("p64_fill_a", fill, 1);
    run_to(255);
    check("p64_fill_b", fill, 1);
    step();
    check("p64_fill_load", fill, 0);
    check("p64_no_ur", underrun, 0);
    check("p64_pstart", period_start, 1);
    measure(64, h, s, u);
    check("p64_highs", h, 64);
    check("p64_shape", s, 0);
    check("p64_ur", u, 0);
    check("p64_repeat_ur", underrun, 1);

    // Back-to-back ordering and repeat on underrun
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = seq[k][7:0];
      step();
    end
    in_valid = 1'b0;
    check("seq_fill", fill, 4);
    check("seq_ready", in_ready, 0);
    run_to(0);
    for (int k = 0; k < 4; k++) begin
      measure(seq[k], h, s, u);
      check($sformatf("seq%0d_highs", k), h, seq[k]);
      check($sformatf("seq%0d_shape", k), s, 0);
      check($sformatf("seq%0d_ur", k), u, 0);
    end
    measure(1, h, s, u);
    check("seq_rep_highs", h, 1);
    check("seq_rep_ur", u, 1);

    // Fill to full, 5th sample held across the load
    run_to(250);
    in_valid = 1'b1;
    in_data = 8'd10; step();
    check("full_f1", fill, 1);
    in_data = 8'd20; step();
    in_data = 8'd30; step();
    in_data = 8'd40; step();
    check("full_f4", fill, 4);
    check("full_ready_lo", in_ready, 0);
    in_data = 8'd50; step();
    check("full_load_ready", in_ready, 0);
    check("full_held_fill", fill, 4);
    step();
    check("full_after_load_fill", fill, 3);
    check("full_after_load_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("full_refill", fill, 4);
    check("full_refill_ready", in_ready, 0);
    run_to(0);
    for (int k = 0; k < 4; k++) begin
      measure(drain[k], h, s, u);
      check($sformatf("drain%0d_highs", k), h, drain[k]);
      check($sformatf("drain%0d_shape", k), s, 0);
    end
    check("drain_empty", fill, 0);

    // Push on the load edge itself
    run_to(255);
    in_valid = 1'b1; in_data = 8'd200;
    step();
    in_valid = 1'b0;
    check("edge_ur", underrun, 1);
    check("edge_fill", fill, 1);
    measure(50, h, s, u);
    check("edge_old_highs", h, 50);
    check("edge_old_shape", s, 0);
    check("edge_popped", fill, 0);
    measure(200, h, s, u);
    check("edge_new_highs", h, 200);
    check("edge_new_shape", s, 0);
    check("edge_new_ur", u, 0);

    // Underrun counter saturation
    do_reset();
    check("sat_rst_ucnt", underrun_count, 0);
    repeat (15 * 256) step();
    check("sat_15", underrun_count, 15);
    repeat (5 * 256) step();
    check("sat_hold", underrun_count, 15);

    // Mid-period reset with a loaded duty and a part-full FIFO
    in_valid = 1'b1; in_data = 8'd200;
    step();
    in_valid = 1'b0;
    run_to(0);
    in_valid = 1'b1;
    in_data = 8'd90; step();
    in_data = 8'd91; step();
    in_data = 8'd92; step();
    in_valid = 1'b0;
    run_to(100);
    check("mid_fill", fill, 3);
    check("mid_pwm", pwm_out, 1);
    do_reset();
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_fill", fill, 0);
    check("mid_rst_ucnt", underrun_count, 0);
    check("mid_rst_pstart", period_start, 1);
    check("mid_rst_ready", in_ready, 1);
    measure(0, h, s, u);
    check("post_rst_highs", h, 0);
    check("post_rst_ur", underrun, 1);
    check("post_rst_ucnt", underrun_count, 1);
    check("all_pstart_err", ps_err, 0);
    check("all_ur_align", ur_mis, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
